// File: rtl/uart_rx_mmio.sv
// UART receiver with a small RX FIFO behind a memory-mapped register window.
// RXDATA pops the oldest byte on read; STATUS reports FIFO state and sticky OVR/FERR flags.
module uart_rx_mmio #(
  parameter int unsigned CLOCK_DIVIDER = 868,
  parameter int unsigned FIFO_LOG2     = 2,
  parameter logic [31:0] BASE          = 32'h7000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        rx,
  input  logic        mem_valid,
  input  logic        mem_write,
  input  logic [3:0]  mem_wmask,
  input  logic [31:0] mem_wdata,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_rdata,
  output logic        rdata_hit,
  output logic        irq_rx
);

  localparam int unsigned           DEPTH       = 1 << FIFO_LOG2;
  localparam logic [15:0]           HALF_M1     = 16'(CLOCK_DIVIDER / 2 - 1);
  localparam logic [15:0]           FULL_M1     = 16'(CLOCK_DIVIDER - 1);
  localparam logic [31:0]           ADDR_RXDATA = BASE + 32'h4;
  localparam logic [31:0]           ADDR_STATUS = BASE + 32'h10;
  localparam logic [FIFO_LOG2-1:0]  PTR_ONE     = FIFO_LOG2'(1);
  localparam logic [FIFO_LOG2:0]    CNT_ONE     = (FIFO_LOG2 + 1)'(1);
  localparam logic [FIFO_LOG2:0]    CNT_FULL    = (FIFO_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHIGH} state_e;

  state_e                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic                   rx_s1_q, rx_s2_q, rx_s;
  logic                   push, ferr_set;

  logic [7:0]             fifo_q [DEPTH];
  logic [FIFO_LOG2-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_LOG2:0]     count_q, count_d;
  logic                   ovr_q, ovr_d, ferr_q, ferr_d;
  logic                   rd_req, hit_rx, hit_st, empty, full, pop, push_ok, ovr_set, clr;
  logic [31:0]            status, rdata_d;
  logic                   hit_d;
  logic                   unused_bits;

  assign rx_s = rx_s2_q;

  // Frame FSM: counter holds cycles until the next sample point
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          cnt_d   = HALF_M1;
          state_d = START;
        end
      end
      START: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (!rx_s) begin
          cnt_d   = FULL_M1;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = FULL_M1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else if (rx_s) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          ferr_set = 1'b1;
          state_d  = WAITHIGH;
        end
      end
      WAITHIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd_req  = mem_valid & ~mem_write;
  assign hit_rx  = (mem_addr == ADDR_RXDATA);
  assign hit_st  = (mem_addr == ADDR_STATUS);
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_FULL);
  assign pop     = rd_req & hit_rx & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte
  assign push_ok = push & (~full | pop);
  assign ovr_set = push & full & ~pop;
  assign clr     = mem_valid & mem_write & hit_st & mem_wmask[0];
  assign status  = {28'b0, ferr_q, ovr_q, ~empty, 1'b1};

  assign unused_bits = ^{mem_wdata[31:4], mem_wdata[1:0], mem_wmask[3:1]};

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop) count_d = count_q + CNT_ONE;
    else if (pop && !push_ok) count_d = count_q - CNT_ONE;
    ovr_d    = ovr_set | (ovr_q & ~(clr & mem_wdata[2]));
    ferr_d   = ferr_set | (ferr_q & ~(clr & mem_wdata[3]));
    hit_d    = rd_req & (hit_rx | hit_st);
    rdata_d  = 32'h0;
    if (rd_req && hit_rx) rdata_d = empty ? 32'hFFFF_FFFF : {24'b0, fifo_q[rd_ptr_q]};
    else if (rd_req && hit_st) rdata_d = status;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      mem_rdata <= 32'h0;
      rdata_hit <= 1'b0;
      irq_rx    <= 1'b0;
    end else begin
      rx_s1_q   <= rx;
      rx_s2_q   <= rx_s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovr_q     <= ovr_d;
      ferr_q    <= ferr_d;
      mem_rdata <= rdata_d;
      rdata_hit <= hit_d;
      irq_rx    <= ~empty;
    end
  end

  // Datapath storage carries no reset; pointers and count qualify its contents
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push_ok) fifo_q[wr_ptr_q] <= shift_q;
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio: serial frames in, bus reads out, checked
// against a byte scoreboard plus a small OVR/FERR flag model.
module tb_uart_rx_mmio;
  localparam int unsigned CD   = 16;
  localparam logic [31:0] BASE = 32'h7000_0000;
  localparam logic [31:0] A_RX = BASE + 32'h4;
  localparam logic [31:0] A_ST = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        rstn, rx, mem_valid, mem_write;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata, mem_addr, mem_rdata;
  logic        rdata_hit, irq_rx;

  always #5 clk = ~clk;

  uart_rx_mmio #(.CLOCK_DIVIDER(CD), .FIFO_LOG2(2), .BASE(BASE)) dut (
    .clk(clk), .rstn(rstn), .rx(rx),
    .mem_valid(mem_valid), .mem_write(mem_write), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .rdata_hit(rdata_hit), .irq_rx(irq_rx)
  );

  int checks = 0;
  int failures = 0;
  logic [7:0] sb [$];
  logic m_ovr, m_ferr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    return {28'b0, m_ferr, m_ovr, (sb.size() != 0), 1'b1};
  endfunction

  function automatic logic [31:0] exp_rx();
    if (sb.size() == 0) return 32'hFFFF_FFFF;
    return {24'b0, sb.pop_front()};
  endfunction

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] d, output logic h);
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_write = 1'b0; mem_addr = addr;
    @(posedge clk); #1;
    mem_valid = 1'b0;
    d = mem_rdata;
    h = rdata_hit;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] wm);
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_write = 1'b1; mem_addr = addr; mem_wdata = wd; mem_wmask = wm;
    @(posedge clk); #1;
    mem_valid = 1'b0; mem_write = 1'b0; mem_wmask = 4'h0;
  endtask

  task automatic read_status(input string tag);
    logic [31:0] d;
    logic h;
    logic [31:0] e;
    e = exp_status();
    bus_read(A_ST, d, h);
    check(tag, d, e);
    check({tag, "_hit"}, {31'b0, h}, 32'd1);
  endtask

  task automatic read_rx(input string tag);
    logic [31:0] d;
    logic h;
    logic [31:0] e;
    e = exp_rx();
    bus_read(A_RX, d, h);
    check(tag, d, e);
    check({tag, "_hit"}, {31'b0, h}, 32'd1);
  endtask

  task automatic read_rx_b2b(input string tag);
    logic [31:0] e0, e1;
    e0 = exp_rx();
    e1 = exp_rx();
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_write = 1'b0; mem_addr = A_RX;
    @(posedge clk); #1;
    check({tag, "_0"}, mem_rdata, e0);
    @(posedge clk); #1;
    mem_valid = 1'b0;
    check({tag, "_1"}, mem_rdata, e1);
  endtask

  // Start bit, 8 data bits LSB first, then the stop level for stop_cycles, then idle
  task automatic send_frame(input logic [7:0] b, input int stop_cycles, input logic stop_lvl);
    @(posedge clk); #1 rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CD) @(posedge clk);
      #1 rx = b[i];
    end
    repeat (CD) @(posedge clk);
    #1 rx = stop_lvl;
    repeat (stop_cycles) @(posedge clk);
    #1 rx = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_valid(input logic [7:0] b);
    send_frame(b, CD, 1'b1);
    if (sb.size() < 4) sb.push_back(b);
    else m_ovr = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    logic h;
    logic [7:0] five [5];
    five = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    rstn = 1'b0; rx = 1'b1; mem_valid = 1'b0; mem_write = 1'b0;
    mem_wmask = 4'h0; mem_wdata = 32'h0; mem_addr = 32'h0;
    m_ovr = 1'b0; m_ferr = 1'b0;

    // Outputs stay quiet in reset even with a read request present
    repeat (2) @(posedge clk);
    #1 mem_valid = 1'b1; mem_addr = A_ST;
    @(posedge clk); #1;
    check("rst_rdata", mem_rdata, 32'h0);
    check("rst_hit", {31'b0, rdata_hit}, 32'd0);
    check("rst_irq", {31'b0, irq_rx}, 32'd0);
    mem_valid = 1'b0;
    rstn = 1'b1;
    repeat (4) @(posedge clk);
    read_status("status_idle");

    // Single byte
    send_valid(8'h41);
    check("irq_set", {31'b0, irq_rx}, 32'd1);
    read_status("status_41");
    read_rx("rx_41");
    read_status("status_41_after");
    check("irq_clear", {31'b0, irq_rx}, 32'd0);

    // Overflow: fifth byte dropped
    for (int i = 0; i < 5; i++) send_valid(five[i]);
    read_status("status_ovr");
    for (int i = 0; i < 5; i++) read_rx("rx_fill");
    bus_write(A_ST, 32'h4, 4'b0010);
    read_status("status_ovr_nomask");
    bus_write(A_ST, 32'h4, 4'b0001);
    m_ovr = 1'b0;
    read_status("status_ovr_clr");

    // Framing error
    send_frame(8'hA5, 20, 1'b0);
    m_ferr = 1'b1;
    read_status("status_ferr");
    bus_write(A_ST, 32'h8, 4'b0001);
    m_ferr = 1'b0;
    read_status("status_ferr_clr");

    // Short glitch is rejected at the start-bit midpoint
    @(posedge clk); #1 rx = 1'b0;
    repeat (6) @(posedge clk);
    #1 rx = 1'b1;
    repeat (30) @(posedge clk);
    read_status("status_glitch");
    send_valid(8'h5A);
    bus_write(A_RX, 32'hFFFF_FFFF, 4'hF);
    read_status("status_5a");
    read_rx("rx_5a");
    bus_read(BASE + 32'h8, d, h);
    check("other_rdata", d, 32'h0);
    check("other_hit", {31'b0, h}, 32'd0);

    // Pop in the same cycle as a push into a full FIFO (push lands 155 edges after the start edge)
    for (int i = 0; i < 4; i++) send_valid(8'h61 + 8'(i));
    fork
      send_frame(8'h65, CD, 1'b1);
      begin
        repeat (154) @(posedge clk);
        read_rx("rx_push_pop");
      end
    join
    sb.push_back(8'h65);
    read_status("status_push_pop");
    read_rx_b2b("rx_b2b_a");
    read_rx_b2b("rx_b2b_b");
    read_rx("rx_drained");

    // Reset pulse during DATA of 0x77, with a stale byte already queued
    send_valid(8'h66);
    fork
      send_frame(8'h77, CD, 1'b1);
      begin
        repeat (100) @(posedge clk);
        #1 rstn = 1'b0;
        @(posedge clk); #1;
        check("midrst_irq", {31'b0, irq_rx}, 32'd0);
        check("midrst_hit", {31'b0, rdata_hit}, 32'd0);
        rstn = 1'b1;
        sb.delete();
        m_ovr = 1'b0;
        m_ferr = 1'b0;
        read_status("status_midrst");
      end
    join
    // The low MSB of 0x77 after reset looks like a fresh start bit; the idle line yields 0xFF
    repeat (200) @(posedge clk);
    sb.push_back(8'hFF);
    read_rx("rx_after_rst_tail");
    send_valid(8'h3C);
    read_rx("rx_3c");
    read_status("status_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
